// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt/ERET sequencer: writes EPC/STATUS, strobes CAUSE, then flushes and redirects.
// Latency: EXC with EXL=0 -> EPC, STATUS, FLUSH at cycles 1/2/3; EXC with EXL=1 or ERET -> STATUS, FLUSH at cycles 1/2.
// Backpressure: busy_o stalls the pipeline from the accept cycle until FLUSH; requests seen while not idle are ignored.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   inst_*, exc_*, eret_i  MEM-stage instruction and its exception/ERET request
//   status_i/cause_i/epc_i current CP0 register values
//   cp0_we_o/waddr/wdata   CP0 write port (EPC, STATUS)
//   cause_upd_o/exccode/bd CAUSE.ExcCode/BD load strobe
//   busy_o                 stall request (combinational)
//   flush_o/new_pc_o       one-cycle flush plus redirect PC
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
   parameter logic [4:0]  CP0_STATUS_ADDR = 5'd12,
   parameter logic [4:0]  CP0_EPC_ADDR    = 5'd14
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic [31:0] inst_pc_i,
   input  logic        inst_bd_i,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_code_i,
   input  logic        eret_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic        cp0_we_o,
   output logic [4:0]  cp0_waddr_o,
   output logic [31:0] cp0_wdata_o,
   output logic        cause_upd_o,
   output logic [4:0]  cause_exccode_o,
   output logic        cause_bd_o,
   output logic        busy_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   typedef enum logic [1:0] {S_IDLE, S_EPC, S_STAT, S_FLUSH} state_t;

   state_t      state;
   logic [31:0] cap_status;
   logic [31:0] cap_epc;
   logic        cap_exc;

   logic        int_pend;
   logic        acc_exc;
   logic        acc_eret;
   logic        accept;
   logic [4:0]  acc_code;
   logic [31:0] acc_epc_val;
   logic        unused_cause;

   // Interrupt only when enabled, not already at exception level, and some
   // pending line is unmasked; it also needs a real instruction to attach EPC to.
   assign int_pend = inst_valid_i & status_i[0] & ~status_i[1] &
                     (|(cause_i[15:8] & status_i[15:8]));

   // Interrupts and synchronous exceptions share the exception path; ERET loses to both.
   assign acc_exc     = int_pend | (inst_valid_i & exc_valid_i);
   assign acc_eret    = ~acc_exc & inst_valid_i & eret_i;
   assign accept      = (state == S_IDLE) & (acc_exc | acc_eret);
   assign acc_code    = int_pend ? 5'd0 : exc_code_i;
   assign acc_epc_val = inst_bd_i ? (inst_pc_i - 32'd4) : inst_pc_i;

   assign busy_o = accept | (state == S_EPC) | (state == S_STAT);

   assign unused_cause = ^{cause_i[30:16], cause_i[7:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         cap_status      <= '0;
         cap_epc         <= '0;
         cap_exc         <= 1'b0;
         cp0_we_o        <= 1'b0;
         cp0_waddr_o     <= '0;
         cp0_wdata_o     <= '0;
         cause_upd_o     <= 1'b0;
         cause_exccode_o <= '0;
         cause_bd_o      <= 1'b0;
         flush_o         <= 1'b0;
         new_pc_o        <= '0;
      end else begin
         // Outputs are produced on the edge that enters a state, so they are
         // valid exactly while that state is occupied.
         cp0_we_o        <= 1'b0;
         cp0_waddr_o     <= '0;
         cp0_wdata_o     <= '0;
         cause_upd_o     <= 1'b0;
         cause_exccode_o <= '0;
         cause_bd_o      <= 1'b0;
         flush_o         <= 1'b0;
         new_pc_o        <= '0;

         case (state)
            S_IDLE: begin
               if (acc_exc | acc_eret) begin
                  cap_status <= status_i;
                  cap_epc    <= epc_i;
                  cap_exc    <= acc_exc;
                  if (acc_exc & ~status_i[1]) begin
                     state           <= S_EPC;
                     cp0_we_o        <= 1'b1;
                     cp0_waddr_o     <= CP0_EPC_ADDR;
                     cp0_wdata_o     <= acc_epc_val;
                     cause_upd_o     <= 1'b1;
                     cause_exccode_o <= acc_code;
                     cause_bd_o      <= inst_bd_i;
                  end else begin
                     state       <= S_STAT;
                     cp0_we_o    <= 1'b1;
                     cp0_waddr_o <= CP0_STATUS_ADDR;
                     cp0_wdata_o <= acc_exc ? (status_i | 32'h2) : (status_i & ~32'h2);
                     // Nested exception: EPC is preserved, so CAUSE.BD keeps
                     // its old value and only ExcCode really changes.
                     if (acc_exc) begin
                        cause_upd_o     <= 1'b1;
                        cause_exccode_o <= acc_code;
                        cause_bd_o      <= cause_i[31];
                     end
                  end
               end
            end
            S_EPC: begin
               // Only exceptions pass through EPC, so EXL is always being set.
               state       <= S_STAT;
               cp0_we_o    <= 1'b1;
               cp0_waddr_o <= CP0_STATUS_ADDR;
               cp0_wdata_o <= cap_status | 32'h2;
            end
            S_STAT: begin
               state    <= S_FLUSH;
               flush_o  <= 1'b1;
               new_pc_o <= cap_exc ? EXC_VECTOR : cap_epc;
            end
            S_FLUSH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_valid_i = 1'b0;
   logic [31:0] inst_pc_i = '0;
   logic        inst_bd_i = 1'b0;
   logic        exc_valid_i = 1'b0;
   logic [4:0]  exc_code_i = '0;
   logic        eret_i = 1'b0;
   logic [31:0] status_i = '0;
   logic [31:0] cause_i = '0;
   logic [31:0] epc_i = '0;
   logic        cp0_we_o;
   logic [4:0]  cp0_waddr_o;
   logic [31:0] cp0_wdata_o;
   logic        cause_upd_o;
   logic [4:0]  cause_exccode_o;
   logic        cause_bd_o;
   logic        busy_o;
   logic        flush_o;
   logic [31:0] new_pc_o;

   always #5 clk = ~clk;

   cp0_exc_ctrl dut (
      .clk(clk), .rst(rst),
      .inst_valid_i(inst_valid_i), .inst_pc_i(inst_pc_i), .inst_bd_i(inst_bd_i),
      .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .eret_i(eret_i),
      .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
      .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
      .cause_upd_o(cause_upd_o), .cause_exccode_o(cause_exccode_o), .cause_bd_o(cause_bd_o),
      .busy_o(busy_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
   );

   // Expected DUT outputs for one clock cycle.
   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        cu;
      logic [4:0]  code;
      logic        cbd;
      logic        fl;
      logic [31:0] npc;
      logic        busy;
   } rec_t;

   rec_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic rec_t idle_rec();
      rec_t r;
      r.we = 0; r.addr = 0; r.data = 0; r.cu = 0; r.code = 0;
      r.cbd = 0; r.fl = 0; r.npc = 0; r.busy = 0;
      return r;
   endfunction

   // Transaction-level reference: decide what the request means and queue the
   // whole expected output sequence for the following cycles.
   function automatic bit model_accept(input logic v, input logic [31:0] pc, input logic bd,
                                       input logic exc, input logic [4:0] code, input logic er,
                                       input logic [31:0] st, input logic [31:0] ca,
                                       input logic [31:0] ep);
      rec_t r;
      bit   irq, is_exc, is_eret;
      logic [4:0] c;
      irq     = v && st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
      is_exc  = irq || (v && exc);
      is_eret = !is_exc && v && er;
      c       = irq ? 5'd0 : code;
      if (is_exc) begin
         if (!st[1]) begin
            r = idle_rec();
            r.we = 1; r.addr = 5'd14; r.data = bd ? pc - 32'd4 : pc;
            r.cu = 1; r.code = c; r.cbd = bd; r.busy = 1;
            q.push_back(r);
         end
         r = idle_rec();
         r.we = 1; r.addr = 5'd12; r.data = st | 32'h2; r.busy = 1;
         if (st[1]) begin r.cu = 1; r.code = c; r.cbd = ca[31]; end
         q.push_back(r);
         r = idle_rec();
         r.fl = 1; r.npc = 32'h20;
         q.push_back(r);
      end else if (is_eret) begin
         r = idle_rec();
         r.we = 1; r.addr = 5'd12; r.data = st & ~32'h2; r.busy = 1;
         q.push_back(r);
         r = idle_rec();
         r.fl = 1; r.npc = ep;
         q.push_back(r);
      end
      return is_exc || is_eret;
   endfunction

   // One cycle: check the outputs of the state currently occupied, then
   // present new inputs (captured at the next rising edge) and check busy.
   task automatic step(input logic v, input logic [31:0] pc, input logic bd, input logic exc,
                       input logic [4:0] code, input logic er, input logic [31:0] st,
                       input logic [31:0] ca, input logic [31:0] ep);
      rec_t r;
      bit   had;
      bit   acc;
      @(negedge clk);
      had = (q.size() > 0);
      r   = had ? q.pop_front() : idle_rec();
      check("cp0_we", {31'd0, cp0_we_o}, {31'd0, r.we});
      check("cp0_waddr", {27'd0, cp0_waddr_o}, {27'd0, r.addr});
      check("cp0_wdata", cp0_wdata_o, r.data);
      check("cause_upd", {31'd0, cause_upd_o}, {31'd0, r.cu});
      if (r.cu) begin
         check("cause_code", {27'd0, cause_exccode_o}, {27'd0, r.code});
         check("cause_bd", {31'd0, cause_bd_o}, {31'd0, r.cbd});
      end
      check("flush", {31'd0, flush_o}, {31'd0, r.fl});
      check("new_pc", new_pc_o, r.npc);
      inst_valid_i = v; inst_pc_i = pc; inst_bd_i = bd; exc_valid_i = exc;
      exc_code_i = code; eret_i = er; status_i = st; cause_i = ca; epc_i = ep;
      #1;
      if (had) begin
         check("busy_seq", {31'd0, busy_o}, {31'd0, r.busy});
      end else begin
         acc = model_accept(v, pc, bd, exc, code, er, st, ca, ep);
         check("busy_idle", {31'd0, busy_o}, {31'd0, acc});
      end
   endtask

   task automatic idle_step();
      step(0, 32'h0, 0, 0, 5'd0, 0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_we", {31'd0, cp0_we_o}, 32'd0);
      check("rst_flush", {31'd0, flush_o}, 32'd0);
      check("rst_npc", new_pc_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_step();

      // Hardware interrupt, EXL=0, not in delay slot.
      step(1, 32'h0000_0100, 0, 0, 5'd0, 0, 32'h1000_0401, 32'h0000_0400, 32'h0);
      idle_step();
      check("irq_epc_addr", {27'd0, cp0_waddr_o}, 32'd14);
      check("irq_epc_data", cp0_wdata_o, 32'h0000_0100);
      check("irq_code", {27'd0, cause_exccode_o}, 32'd0);
      idle_step();
      check("irq_status", cp0_wdata_o, 32'h1000_0403);
      idle_step();
      check("irq_flush", {31'd0, flush_o}, 32'd1);
      check("irq_newpc", new_pc_o, 32'h20);
      idle_step();

      // Syscall in a branch delay slot.
      step(1, 32'h0000_0208, 1, 1, 5'd8, 0, 32'h1000_0000, 32'h0, 32'h0);
      idle_step();
      check("sys_epc", cp0_wdata_o, 32'h0000_0204);
      check("sys_bd", {31'd0, cause_bd_o}, 32'd1);
      repeat (3) idle_step();

      // Nested exception (EXL already set): STATUS then flush only.
      step(1, 32'h0000_0400, 0, 1, 5'd4, 0, 32'h1000_0003, 32'h8000_0000, 32'h0);
      idle_step();
      check("nest_addr", {27'd0, cp0_waddr_o}, 32'd12);
      check("nest_bd_kept", {31'd0, cause_bd_o}, 32'd1);
      repeat (2) idle_step();

      // ERET.
      step(1, 32'h0000_0500, 0, 0, 5'd0, 1, 32'h1000_0003, 32'h0, 32'h0000_0300);
      idle_step();
      check("eret_status", cp0_wdata_o, 32'h1000_0001);
      idle_step();
      check("eret_newpc", new_pc_o, 32'h0000_0300);

      // Interrupt beats exception code 10; further requests while busy are ignored.
      step(1, 32'h0000_0600, 0, 1, 5'd10, 1, 32'h1000_0401, 32'h0000_0400, 32'h0);
      step(1, 32'h0000_0604, 0, 1, 5'd12, 0, 32'h1000_0000, 32'h0, 32'h0);
      check("prio_code", {27'd0, cause_exccode_o}, 32'd0);
      step(1, 32'h0000_0608, 0, 0, 5'd0, 1, 32'h1000_0000, 32'h0, 32'h0);
      step(1, 32'h0000_060c, 0, 1, 5'd3, 0, 32'h1000_0000, 32'h0, 32'h0);
      // Back-to-back: the request just presented during FLUSH is dropped; IDLE follows.
      idle_step();
      idle_step();

      // Reset in the middle of the EPC state abandons the sequence.
      step(1, 32'h0000_0700, 0, 1, 5'd5, 0, 32'h0, 32'h0, 32'h0);
      idle_step();
      rst = 1'b1;
      #1;
      check("midrst_we", {31'd0, cp0_we_o}, 32'd0);
      check("midrst_upd", {31'd0, cause_upd_o}, 32'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (4) idle_step();

      // Randomized traffic, including requests while busy.
      for (int i = 0; i < 800; i++) begin
         logic [31:0] st;
         logic [31:0] ca;
         st = $urandom;
         ca = $urandom;
         ca[15:8] = ($urandom_range(0, 2) == 0) ? 8'h00 : ca[15:8];
         step(($urandom_range(0, 3) != 0), {$urandom} & ~32'h3, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, 5'($urandom), $urandom_range(0, 3) == 0,
              st, ca, {$urandom} & ~32'h3);
      end
      repeat (4) idle_step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
